bilinear_interp: RTL and testbench

Fully pipelined bilinear interpolator for the rectification datapath. Each valid cycle it accepts the four 8-bit neighbour pixels from the fetch stage (lu, ru, ld, rd) and the 6-bit fractional offsets (dy, dx), and produces one rectified 8-bit pixel. Output comes a fixed four enabled cycles later, with valid/last sideband aligned. It sits between the pixel fetch unit and the output writer/coordinate generator.

---
 rtl/bilinear_interp.sv | 177 +++++++++++++++++
 tb/tb_bilinear_interp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bilinear_interp.sv
// bilinear_interp: four-stage pipelined bilinear interpolator.
// Consumes four neighbour pixels and a (dy, dx) fractional offset each
// enabled cycle and emits the interpolated pixel four enabled cycles later.
// Optional macro INTERP_ROUND_EN: round-half-up in the final stage instead
// of plain truncation. Latency is the same in both builds.
// Reset is asynchronous and active-low on port rst.
module bilinear_interp #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              din_valid,
  input  logic              din_last,
  input  logic [FRAC_W-1:0] dy,
  input  logic [FRAC_W-1:0] dx,
  input  logic [DATA_W-1:0] lu,
  input  logic [DATA_W-1:0] ru,
  input  logic [DATA_W-1:0] ld,
  input  logic [DATA_W-1:0] rd,
  output logic              dout_valid,
  output logic              dout_last,
  output logic [DATA_W-1:0] p
);

  // Weight range is 0..2^FRAC_W, so one extra bit is needed.
  localparam int WGT_W  = FRAC_W + 1;
  localparam int PROD_W = DATA_W + FRAC_W + 1;
  // A weighted pair sums to at most (2^DATA_W-1)*2^FRAC_W.
  localparam int H_W    = DATA_W + FRAC_W;
  localparam int V_W    = DATA_W + 2 * FRAC_W;
  localparam int S_W    = V_W + 1;
  localparam int Q_W    = DATA_W + 1;
  localparam logic [WGT_W-1:0] W_ONE = {1'b1, {FRAC_W{1'b0}}};
`ifdef INTERP_ROUND_EN
  localparam logic [S_W-1:0] RND_HALF = S_W'(1) << (2 * FRAC_W - 1);
`endif

  // Stage 1 state
  logic [PROD_W-1:0] prod_d [4];
  logic [PROD_W-1:0] prod_q [4];
  logic [WGT_W-1:0]  wyu1_d, wyu1_q, wyd1_d, wyd1_q;
  logic              valid1_d, valid1_q, last1_d, last1_q;
  // Stage 2 state
  logic [H_W-1:0]    hu_d, hu_q, hd_d, hd_q;
  logic [WGT_W-1:0]  wyu2_d, wyu2_q, wyd2_d, wyd2_q;
  logic              valid2_d, valid2_q, last2_d, last2_q;
  // Stage 3 state
  logic [V_W-1:0]    vu_d, vu_q, vd_d, vd_q;
  logic              valid3_d, valid3_q, last3_d, last3_q;
  // Stage 4 state
  logic [DATA_W-1:0] p_d, p_q;
  logic              valid4_d, valid4_q, last4_d, last4_q;

  logic [DATA_W-1:0] pix [4];
  logic [WGT_W-1:0]  wxl, wxr;
  logic [S_W-1:0]    s_sum, s_rnd;
  logic [Q_W-1:0]    s_shift;

  // Stage 1: horizontal weights and the four neighbour products.
  always_comb begin
    pix      = '{lu, ru, ld, rd};
    wxl      = W_ONE - WGT_W'(dx);
    wxr      = WGT_W'(dx);
    for (int i = 0; i < 4; i++) begin
      prod_d[i] = PROD_W'(pix[i]) * PROD_W'((i % 2 == 0) ? wxl : wxr);
    end
    wyu1_d   = W_ONE - WGT_W'(dy);
    wyd1_d   = WGT_W'(dy);
    valid1_d = din_valid;
    last1_d  = din_last & din_valid;
  end

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) prod_q[i] <= '0;
      wyu1_q   <= '0;
      wyd1_q   <= '0;
      valid1_q <= 1'b0;
      last1_q  <= 1'b0;
    end else if (clk_en) begin
      for (int i = 0; i < 4; i++) prod_q[i] <= prod_d[i];
      wyu1_q   <= wyu1_d;
      wyd1_q   <= wyd1_d;
      valid1_q <= valid1_d;
      last1_q  <= last1_d;
    end
  end

  // Stage 2: horizontal interpolation of the upper and lower rows.
  always_comb begin
    hu_d     = H_W'(prod_q[0]) + H_W'(prod_q[1]);
    hd_d     = H_W'(prod_q[2]) + H_W'(prod_q[3]);
    wyu2_d   = wyu1_q;
    wyd2_d   = wyd1_q;
    valid2_d = valid1_q;
    last2_d  = last1_q & valid1_q;
  end

  // Stage 2 registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hu_q     <= '0;
      hd_q     <= '0;
      wyu2_q   <= '0;
      wyd2_q   <= '0;
      valid2_q <= 1'b0;
      last2_q  <= 1'b0;
    end else if (clk_en) begin
      hu_q     <= hu_d;
      hd_q     <= hd_d;
      wyu2_q   <= wyu2_d;
      wyd2_q   <= wyd2_d;
      valid2_q <= valid2_d;
      last2_q  <= last2_d;
    end
  end

  // Stage 3: apply the vertical weights to each row result.
  always_comb begin
    vu_d     = V_W'(hu_q) * V_W'(wyu2_q);
    vd_d     = V_W'(hd_q) * V_W'(wyd2_q);
    valid3_d = valid2_q;
    last3_d  = last2_q & valid2_q;
  end

  // Stage 3 registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vu_q     <= '0;
      vd_q     <= '0;
      valid3_q <= 1'b0;
      last3_q  <= 1'b0;
    end else if (clk_en) begin
      vu_q     <= vu_d;
      vd_q     <= vd_d;
      valid3_q <= valid3_d;
      last3_q  <= last3_d;
    end
  end

  // Stage 4: sum, optional rounding, rescale and saturate.
  always_comb begin
    s_sum = S_W'(vu_q) + S_W'(vd_q);
`ifdef INTERP_ROUND_EN
    s_rnd = s_sum + RND_HALF;
`else
    s_rnd = s_sum;
`endif
    s_shift  = Q_W'(s_rnd >> (2 * FRAC_W));
    // Saturation cannot trigger at the default widths but keeps the
    // block safe if the parameters are changed.
    p_d      = s_shift[DATA_W] ? {DATA_W{1'b1}} : s_shift[DATA_W-1:0];
    valid4_d = valid3_q;
    last4_d  = last3_q & valid3_q;
  end

  // Stage 4 registers drive the outputs directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q      <= '0;
      valid4_q <= 1'b0;
      last4_q  <= 1'b0;
    end else if (clk_en) begin
      p_q      <= p_d;
      valid4_q <= valid4_d;
      last4_q  <= last4_d;
    end
  end

  assign p          = p_q;
  assign dout_valid = valid4_q;
  assign dout_last  = last4_q;

endmodule

// File: tb/tb_bilinear_interp.sv
// tb_bilinear_interp: scoreboard bench for bilinear_interp.
// The driver pushes the expected pixel (computed from the bilinear formula
// over all four weight products) with the enabled-edge count at which it
// must appear; an independent monitor pops and compares fresh outputs.
module tb_bilinear_interp;

  localparam int FW  = 6;
  localparam int ONE = 64;

  logic       clk = 1'b0;
  logic       rst, clk_en, din_valid, din_last;
  logic [5:0] dy, dx;
  logic [7:0] lu, ru, ld, rd;
  logic       dout_valid, dout_last;
  logic [7:0] p;

  typedef struct {
    int         due;
    logic [7:0] pix;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   en_cnt  = 0;

  always #5 clk = ~clk;

  bilinear_interp dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .dy         (dy),
    .dx         (dx),
    .lu         (lu),
    .ru         (ru),
    .ld         (ld),
    .rd         (rd),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .p          (p)
  );

  // Reference: weighted average of the four neighbours, rescaled by 2^(2*FW).
  function automatic logic [7:0] model(input int y, input int x, input int a,
                                       input int b, input int c, input int d);
    int s;
    s = a * (ONE - x) * (ONE - y) + b * x * (ONE - y)
      + c * (ONE - x) * y + d * x * y;
`ifdef INTERP_ROUND_EN
    s = s + (1 << (2 * FW - 1));
`endif
    s = s / (1 << (2 * FW));
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // One enabled cycle of stimulus; valid samples get an expectation.
  task automatic drive(input logic v, input logic l, input int y, input int x,
                       input int a, input int b, input int c, input int d);
    exp_t e;
    clk_en    = 1'b1;
    din_valid = v;
    din_last  = l;
    dy = 6'(y); dx = 6'(x);
    lu = 8'(a); ru = 8'(b); ld = 8'(c); rd = 8'(d);
    if (v) begin
      e.due  = en_cnt + 4;
      e.pix  = model(y, x, a, b, c, d);
      e.last = l;
      sb.push_back(e);
      $display("[TB] issue dy=%0d dx=%0d lu=%0d ru=%0d ld=%0d rd=%0d last=%0b exp_p=%0d",
               y, x, a, b, c, d, l, e.pix);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  // Disabled cycles with garbage on the inputs, which must be ignored.
  task automatic freeze(input int n);
    clk_en    = 1'b0;
    din_valid = 1'($urandom);
    din_last  = 1'($urandom);
    dy = 6'($urandom); dx = 6'($urandom);
    lu = 8'($urandom); ru = 8'($urandom); ld = 8'($urandom); rd = 8'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic v, input logic l);
    int y, x;
    y = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 63) : int'($urandom_range(0, 63));
    x = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 63) : int'($urandom_range(0, 63));
    drive(v, l, y, x, $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  // Monitor: counts enabled edges and checks outputs at the falling edge.
  initial begin : monitor
    logic       en_s, rst_s;
    logic [7:0] prev_p;
    logic       prev_v, prev_l;
    exp_t       e;
    prev_p = '0; prev_v = 1'b0; prev_l = 1'b0;
    forever begin
      @(posedge clk);
      en_s  = clk_en;
      rst_s = rst;
      if (en_s && rst_s) en_cnt++;
      @(negedge clk);
      if (!rst) begin
        chk("reset_p", int'(p), 0);
        chk("reset_valid", int'(dout_valid), 0);
        chk("reset_last", int'(dout_last), 0);
      end else if (!en_s || !rst_s) begin
        chk("hold_p", int'(p), int'(prev_p));
        chk("hold_valid", int'(dout_valid), int'(prev_v));
        chk("hold_last", int'(dout_last), int'(prev_l));
      end else if (dout_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", en_cnt, e.due);
          chk("pixel", int'(p), int'(e.pix));
          chk("last", int'(dout_last), int'(e.last));
          $display("[TB] output p=%0d last=%0b exp_p=%0d exp_last=%0b",
                   p, dout_last, e.pix, e.last);
        end
      end else if (sb.size() > 0 && sb[0].due <= en_cnt) begin
        e = sb.pop_front();
        chk("missing_output", 0, 1);
      end
      if (dout_last && !dout_valid) chk("last_without_valid", 1, 0);
      prev_p = p; prev_v = dout_valid; prev_l = dout_last;
    end
  end

  // Stimulus sequence.
  initial begin : driver
    int k;
    rst = 1'b1; clk_en = 1'b0; din_valid = 1'b0; din_last = 1'b0;
    dy = '0; dx = '0; lu = '0; ru = '0; ld = '0; rd = '0;
    #1 rst = 1'b0;
    #1;
    chk("por_p", int'(p), 0);
    chk("por_valid", int'(dout_valid), 0);
    chk("por_last", int'(dout_last), 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;

    // Flat patch, single pulse.
    drive(1'b1, 1'b0, 13, 13, 100, 100, 100, 100);
    idle(6);
    // Corner cases of the fractions.
    drive(1'b1, 1'b0, 0, 0, 37, 200, 200, 200);
    drive(1'b1, 1'b0, 0, 63, 0, 255, 0, 255);
    idle(6);
    // Exact half-way point: rounding mode decides.
    drive(1'b1, 1'b0, 0, 32, 0, 255, 0, 255);
    idle(6);
    // Full-scale stream of ten with last on the tenth.
    for (int i = 0; i < 10; i++) drive(1'b1, (i == 9), 63, 63, 255, 255, 255, 255);
    idle(6);
    // Freeze after the second of six samples.
    for (int i = 0; i < 6; i++) begin
      drive_rand(1'b1, (i == 5));
      if (i == 1) freeze(3);
    end
    idle(6);

    // Reset with samples in flight: one at the output, two behind it.
    for (int i = 0; i < 3; i++) drive_rand(1'b1, (i == 2));
    idle(1);
    #1 rst = 1'b0;
    sb.delete();
    #1;
    chk("midreset_p", int'(p), 0);
    chk("midreset_valid", int'(dout_valid), 0);
    chk("midreset_last", int'(dout_last), 0);
    clk_en = 1'b0;
    @(posedge clk); #1 clk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    idle(8);
    chk("post_reset_idle_valid", int'(dout_valid), 0);
    drive_rand(1'b1, 1'b1);
    idle(6);

    // Randomized traffic with random stalls, gaps and last flags.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) freeze($urandom_range(1, 3));
      else drive_rand(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    end

    // Drain, bounded.
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      idle(1);
      k++;
    end
    idle(2);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
